pipe_hazard_ctrl: RTL and testbench

Central pipeline controller for the 5-stage core. It resolves load-use hazards between the ID and EX stages. It squashes wrong-path instructions when a branch resolves taken in MEM, and it sequences the data-memory handshake for MEM-stage loads and stores, freezing the whole pipeline while memory is busy. It drives the write-enable and flush inputs of PC, IF/ID, ID/EX and EX/MEM, and keeps saturating stall and flush counters for performance monitoring.

---
 rtl/pipe_hazard_ctrl.sv | 126 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard controller for the 5-stage core: load-use stalls, taken-branch
// squashes in MEM, data-memory handshake with timeout, and stall/flush counters.
module pipe_hazard_ctrl #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             MemRead_EX,
    input  logic [4:0]       wrin_EX,
    input  logic [4:0]       rs_ID,
    input  logic [4:0]       rt_ID,
    input  logic             uses_rt_ID,
    input  logic             Branch_MEM,
    input  logic             ZERO_MEM,
    input  logic             MemRead_MEM,
    input  logic             MemWrite_MEM,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             pipe_en,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             PCSrc,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic             EX_MEM_Flush,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_ERROR    = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [WC_W-1:0] wcnt, wcnt_n;
    logic            memop, taken, lu;
    logic            waiting, lu_stall, stall_evt;

    assign memop = MemRead_MEM | MemWrite_MEM;
    assign taken = Branch_MEM & ZERO_MEM;
    assign lu    = MemRead_EX & (wrin_EX != 5'd0) &
                   ((wrin_EX == rs_ID) | (uses_rt_ID & (wrin_EX == rt_ID)));

    always_comb begin
        state_n      = state;
        wcnt_n       = wcnt;
        waiting      = 1'b0;
        lu_stall     = 1'b0;
        mem_req      = 1'b0;
        pipe_en      = 1'b0;
        PCWrite      = 1'b0;
        IF_ID_Write  = 1'b0;
        PCSrc        = 1'b0;
        IF_ID_Flush  = 1'b0;
        ID_EX_Flush  = 1'b0;
        EX_MEM_Flush = 1'b0;
        case (state)
            S_RUN, S_MEM_WAIT: begin
                mem_req = memop | (state == S_MEM_WAIT);
                waiting = (state == S_MEM_WAIT) ? !mem_ready : (memop & !mem_ready);
                if (waiting) begin
                    // Counter holds the number of frozen cycles so far, including this one
                    wcnt_n  = (state == S_RUN) ? WC_W'(1) : wcnt + 1'b1;
                    state_n = (wcnt_n == WC_W'(MEM_TIMEOUT)) ? S_ERROR : S_MEM_WAIT;
                end else begin
                    state_n = S_RUN;
                    wcnt_n  = '0;
                    pipe_en = 1'b1;
                    if (taken) begin
                        PCSrc        = 1'b1;
                        PCWrite      = 1'b1;
                        IF_ID_Write  = 1'b1;
                        IF_ID_Flush  = 1'b1;
                        ID_EX_Flush  = 1'b1;
                        EX_MEM_Flush = 1'b1;
                    end else if (lu) begin
                        ID_EX_Flush = 1'b1;
                        lu_stall    = 1'b1;
                    end else begin
                        PCWrite     = 1'b1;
                        IF_ID_Write = 1'b1;
                    end
                end
            end
            default: ;
        endcase
        // Reset forces every control line low regardless of state/inputs
        if (!RESET_N) begin
            lu_stall     = 1'b0;
            mem_req      = 1'b0;
            pipe_en      = 1'b0;
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            PCSrc        = 1'b0;
            IF_ID_Flush  = 1'b0;
            ID_EX_Flush  = 1'b0;
            EX_MEM_Flush = 1'b0;
        end
    end

    assign mem_err   = (state == S_ERROR);
    assign stall_evt = !pipe_en | lu_stall;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= S_RUN;
            wcnt        <= '0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            state <= state_n;
            wcnt  <= wcnt_n;
            if (stall_evt && (stall_count != {CNT_W{1'b1}}))
                stall_count <= stall_count + 1'b1;
            if (PCSrc && (flush_count != {CNT_W{1'b1}}))
                flush_count <= flush_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: vector table, directed multi-cycle sequences and
// random traffic against a cycle-level reference model; a CNT_W=4 copy checks saturation.
module tb_pipe_hazard_ctrl;

    localparam int TO = 16;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       MemRead_EX = 0, uses_rt_ID = 0, Branch_MEM = 0, ZERO_MEM = 0;
    logic       MemRead_MEM = 0, MemWrite_MEM = 0, mem_ready = 0;
    logic [4:0] wrin_EX = 0, rs_ID = 0, rt_ID = 0;

    logic        mem_req, pipe_en, PCWrite, IF_ID_Write, PCSrc;
    logic        IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, mem_err;
    logic [31:0] stall_count, flush_count;

    logic        mem_req4, pipe_en4, PCWrite4, IF_ID_Write4, PCSrc4;
    logic        IF_ID_Flush4, ID_EX_Flush4, EX_MEM_Flush4, mem_err4;
    logic [3:0]  stall_count4, flush_count4;

    pipe_hazard_ctrl #(.CNT_W(32), .MEM_TIMEOUT(TO)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .MemRead_EX(MemRead_EX), .wrin_EX(wrin_EX),
        .rs_ID(rs_ID), .rt_ID(rt_ID), .uses_rt_ID(uses_rt_ID), .Branch_MEM(Branch_MEM),
        .ZERO_MEM(ZERO_MEM), .MemRead_MEM(MemRead_MEM), .MemWrite_MEM(MemWrite_MEM),
        .mem_ready(mem_ready), .mem_req(mem_req), .pipe_en(pipe_en), .PCWrite(PCWrite),
        .IF_ID_Write(IF_ID_Write), .PCSrc(PCSrc), .IF_ID_Flush(IF_ID_Flush),
        .ID_EX_Flush(ID_EX_Flush), .EX_MEM_Flush(EX_MEM_Flush), .mem_err(mem_err),
        .stall_count(stall_count), .flush_count(flush_count));

    pipe_hazard_ctrl #(.CNT_W(4), .MEM_TIMEOUT(TO)) dut4 (
        .CLK(CLK), .RESET_N(RESET_N), .MemRead_EX(MemRead_EX), .wrin_EX(wrin_EX),
        .rs_ID(rs_ID), .rt_ID(rt_ID), .uses_rt_ID(uses_rt_ID), .Branch_MEM(Branch_MEM),
        .ZERO_MEM(ZERO_MEM), .MemRead_MEM(MemRead_MEM), .MemWrite_MEM(MemWrite_MEM),
        .mem_ready(mem_ready), .mem_req(mem_req4), .pipe_en(pipe_en4), .PCWrite(PCWrite4),
        .IF_ID_Write(IF_ID_Write4), .PCSrc(PCSrc4), .IF_ID_Flush(IF_ID_Flush4),
        .ID_EX_Flush(ID_EX_Flush4), .EX_MEM_Flush(EX_MEM_Flush4), .mem_err(mem_err4),
        .stall_count(stall_count4), .flush_count(flush_count4));

    always #5 CLK = ~CLK;

    // control bundle order: {mem_req, pipe_en, PCWrite, IF_ID_Write, PCSrc, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush}
    wire [7:0] ctl  = {mem_req, pipe_en, PCWrite, IF_ID_Write, PCSrc,
                       IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush};
    wire [7:0] ctl4 = {mem_req4, pipe_en4, PCWrite4, IF_ID_Write4, PCSrc4,
                       IF_ID_Flush4, ID_EX_Flush4, EX_MEM_Flush4};

    typedef struct {
        logic       mr_ex;
        logic [4:0] wr, rs, rt;
        logic       urt, br, z, mrm, mwm, rdy;
        logic [7:0] exp;
    } vec_t;

    int errors = 0;
    int checks = 0;

    // reference model: frozen-cycle run length, sticky error, unbounded event counts
    int     m_run;
    bit     m_err;
    longint m_stall, m_flush;
    logic [7:0] e_ctl;
    bit     e_frozen, e_stall_evt, e_flush_evt;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic longint sat(input longint v, input longint mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_clear();
        m_run = 0; m_err = 0; m_stall = 0; m_flush = 0;
    endtask

    task automatic model_eval();
        bit memop, taken, hz, busy;
        e_ctl = 8'h00; e_frozen = 0; e_stall_evt = 0; e_flush_evt = 0;
        if (!RESET_N) return;
        if (m_err) begin
            e_stall_evt = 1;
            return;
        end
        memop = MemRead_MEM || MemWrite_MEM;
        taken = Branch_MEM && ZERO_MEM;
        hz = MemRead_EX && wrin_EX != 0 &&
             (wrin_EX == rs_ID || (uses_rt_ID && wrin_EX == rt_ID));
        busy = (m_run > 0) ? !mem_ready : (memop && !mem_ready);
        if (busy) begin
            e_ctl = 8'b1000_0000;
            e_frozen = 1;
            e_stall_evt = 1;
        end else begin
            e_ctl[7] = memop || (m_run > 0);
            if (taken) begin
                e_ctl[6:0] = 7'b111_1111;
                e_flush_evt = 1;
            end else if (hz) begin
                e_ctl[6:0] = 7'b100_0010;
                e_stall_evt = 1;
            end else begin
                e_ctl[6:0] = 7'b111_0000;
            end
        end
    endtask

    task automatic model_update();
        if (!RESET_N) begin
            model_clear();
            return;
        end
        if (e_stall_evt) m_stall++;
        if (e_flush_evt) m_flush++;
        if (!m_err) begin
            if (e_frozen) begin
                m_run++;
                if (m_run >= TO) m_err = 1;
            end else begin
                m_run = 0;
            end
        end
    endtask

    task automatic set_in(input logic mr_ex, input logic [4:0] wr, input logic [4:0] rs,
                          input logic [4:0] rt, input logic urt, input logic br, input logic z,
                          input logic mrm, input logic mwm, input logic rdy);
        MemRead_EX = mr_ex; wrin_EX = wr; rs_ID = rs; rt_ID = rt; uses_rt_ID = urt;
        Branch_MEM = br; ZERO_MEM = z; MemRead_MEM = mrm; MemWrite_MEM = mwm; mem_ready = rdy;
    endtask

    // Called just after a falling edge with inputs applied; leaves at the next falling edge.
    task automatic step(input string nm, input bit use_tab, input logic [7:0] tab);
        #1;
        model_eval();
        chk({nm, ".ctl"}, 64'(ctl), 64'(use_tab ? tab : e_ctl));
        chk({nm, ".ctl4"}, 64'(ctl4), 64'(e_ctl));
        chk({nm, ".mem_err"}, 64'(mem_err), 64'(m_err));
        chk({nm, ".mem_err4"}, 64'(mem_err4), 64'(m_err));
        chk({nm, ".stall"}, 64'(stall_count), 64'(sat(m_stall, 64'hFFFF_FFFF)));
        chk({nm, ".flush"}, 64'(flush_count), 64'(sat(m_flush, 64'hFFFF_FFFF)));
        chk({nm, ".stall4"}, 64'(stall_count4), 64'(sat(m_stall, 15)));
        chk({nm, ".flush4"}, 64'(flush_count4), 64'(sat(m_flush, 15)));
        @(posedge CLK);
        model_update();
        @(negedge CLK);
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        model_clear();
        step("reset", 1, 8'h00);
        RESET_N = 1'b1;
    endtask

    vec_t tab[$];
    longint s0;

    initial begin
        model_clear();
        tab.push_back('{1, 5'd5, 5'd5, 5'd0, 0, 0, 0, 0, 0, 0, 8'b0100_0010}); // load-use on rs
        tab.push_back('{0, 5'd5, 5'd5, 5'd0, 0, 0, 0, 0, 0, 0, 8'b0111_0000}); // load moved on
        tab.push_back('{1, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 0, 0, 8'b0111_0000}); // $zero never hazards
        tab.push_back('{1, 5'd7, 5'd3, 5'd7, 0, 0, 0, 0, 0, 0, 8'b0111_0000}); // rt not a source
        tab.push_back('{1, 5'd7, 5'd3, 5'd7, 1, 0, 0, 0, 0, 0, 8'b0100_0010}); // rt is a source
        tab.push_back('{1, 5'd5, 5'd5, 5'd0, 0, 1, 1, 0, 0, 0, 8'b0111_1111}); // taken beats lu
        tab.push_back('{0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 0, 0, 8'b0111_0000}); // not taken
        tab.push_back('{0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 1, 8'b1111_0000}); // load, ready at once
        tab.push_back('{0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 0, 1, 1, 8'b1111_1111}); // store + taken
        tab.push_back('{1, 5'd9, 5'd1, 5'd9, 1, 0, 0, 0, 1, 1, 8'b1100_0010}); // store + lu

        // reset holds everything low even with active inputs
        @(negedge CLK);
        set_in(1, 5'd5, 5'd5, 5'd0, 0, 1, 1, 1, 0, 0);
        do_reset();

        foreach (tab[i]) begin
            set_in(tab[i].mr_ex, tab[i].wr, tab[i].rs, tab[i].rt, tab[i].urt,
                   tab[i].br, tab[i].z, tab[i].mrm, tab[i].mwm, tab[i].rdy);
            step($sformatf("vec%0d", i), 1, tab[i].exp);
        end
        chk("lu_then_taken.stall", 64'(stall_count), 64'd3);
        chk("lu_then_taken.flush", 64'(flush_count), 64'd2);

        // load waits 3 cycles, then completes
        s0 = longint'(stall_count);
        for (int k = 0; k < 3; k++) begin
            set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
            step("ldwait", 1, 8'b1000_0000);
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        step("ldrdy", 1, 8'b1111_0000);
        chk("ldwait.stall_delta", 64'(longint'(stall_count) - s0), 64'd3);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("after_ld", 1, 8'b0111_0000);

        // taken branch sitting behind a memory wait flushes on the ready cycle
        for (int k = 0; k < 3; k++) begin
            set_in(1, 5'd4, 5'd4, 5'd0, 0, 1, 1, 1, 0, 0);
            step("brwait", 1, 8'b1000_0000);
        end
        set_in(1, 5'd4, 5'd4, 5'd0, 0, 1, 1, 1, 0, 1);
        step("brrdy", 1, 8'b1111_1111);
        // lu pending behind a wait stalls on the ready cycle, with mem_req still high
        set_in(1, 5'd6, 5'd0, 5'd6, 1, 0, 0, 0, 1, 0);
        step("luwait", 1, 8'b1000_0000);
        set_in(1, 5'd6, 5'd0, 5'd6, 1, 0, 0, 0, 1, 1);
        step("lurdy", 1, 8'b1100_0010);

        // ready arriving on the last permitted wait cycle avoids the error
        for (int k = 0; k < TO - 1; k++) begin
            set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
            step("edge_wait", 0, 8'h00);
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        step("edge_rdy", 1, 8'b1111_0000);
        chk("edge_rdy.no_err", 64'(mem_err), 64'd0);

        // random traffic against the model
        for (int n = 0; n < 1500; n++) begin
            set_in(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                   1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) != 0));
            step("rand", 0, 8'h00);
        end

        // timeout on a store, then hold in ERROR long enough to saturate the 4-bit counter
        do_reset();
        for (int k = 0; k < TO; k++) begin
            set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
            step("to_wait", 1, 8'b1000_0000);
        end
        chk("timeout.mem_err", 64'(mem_err), 64'd1);
        for (int k = 0; k < 5; k++) begin
            set_in(1, 5'd5, 5'd5, 5'd0, 0, 1, 1, 1, 0, 1);
            step("error", 1, 8'h00);
        end
        chk("sat.stall32", 64'(stall_count), 64'd21);
        chk("sat.stall4", 64'(stall_count4), 64'd15);

        // asynchronous reset in the middle of ERROR, checked before any clock edge
        RESET_N = 1'b0;
        model_clear();
        #1;
        chk("arst.mem_err", 64'(mem_err), 64'd0);
        chk("arst.stall", 64'(stall_count), 64'd0);
        chk("arst.stall4", 64'(stall_count4), 64'd0);
        chk("arst.ctl", 64'(ctl), 64'd0);
        @(negedge CLK);
        RESET_N = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("post_arst", 1, 8'b0111_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
